matmul_sequencer: RTL and testbench
===================================

MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 Parameter ELEM_W, default 7, SHALL set element width in bits.
REQ-002 Parameter N, default 3, SHALL set matrix dimension; NELEM = N*N.
REQ-003 i_clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 i_rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 i_in_valid  input  1  SHALL be the upstream element-valid strobe.
REQ-006 i_in_data  input  ELEM_W  SHALL carry one element per transfer: A row-major first, then B row-major.
REQ-007 o_in_ready  output  1  SHALL indicate the block accepts an input element this cycle.
REQ-008 o_mm_trigger  output  1  SHALL be the one-cycle launch pulse to the matmul engine.
REQ-009 o_mm_a, o_mm_b  output  NELEM x ELEM_W  SHALL present the assembled operand matrices.
REQ-010 i_mm_ready  input  1  SHALL be the engine-ready flag.
REQ-011 i_mm_result  input  NELEM x ELEM_W  SHALL be the engine result matrix.
REQ-012 o_out_valid, o_out_data (ELEM_W), o_out_last  output SHALL form the result stream; i_out_ready input 1 SHALL be its backpressure.
REQ-013 o_busy  output  1  SHALL be high in every state except LOAD.

Function
REQ-014 Transfers SHALL occur only on cycles with valid and ready both high (input and output side).
REQ-015 FSM states SHALL be LOAD, LAUNCH, WAIT_BUSY, WAIT_DONE, SETTLE, DRAIN.
REQ-016 LOAD: o_in_ready=1; each transfer SHALL write element index k (0..2*NELEM-1) to A[k] or B[k-NELEM]; after transfer of index 2*NELEM-1 -> LAUNCH.
REQ-017 LAUNCH: o_in_ready=0; when i_mm_ready=1 SHALL assert o_mm_trigger for exactly one cycle -> WAIT_BUSY; while i_mm_ready=0 SHALL hold without triggering.
REQ-018 o_mm_a/o_mm_b SHALL be stable from entry to LAUNCH until exit from SETTLE.
REQ-019 WAIT_BUSY: on i_mm_ready=0 -> WAIT_DONE; if i_mm_ready stays 1 for 4 cycles SHALL return to LAUNCH and re-trigger.
REQ-020 WAIT_DONE: on i_mm_ready=1 -> SETTLE.
REQ-021 SETTLE: SHALL last one cycle, then capture all NELEM i_mm_result elements into a local result register and -> DRAIN.
REQ-022 DRAIN: o_out_valid=1, o_out_data=result[j], j=0..NELEM-1 row-major; o_out_last=1 only at j=NELEM-1; j SHALL advance only on transfer.
REQ-023 With i_out_ready=0, o_out_data and o_out_last SHALL hold unchanged.
REQ-024 Transfer of j=NELEM-1 SHALL return to LOAD with k=0; next input accepted the following cycle.
REQ-025 Arithmetic is performed by the engine modulo 2^ELEM_W; the sequencer SHALL pass results unmodified.
REQ-026 i_in_valid outside LOAD SHALL be ignored (no data consumed).
REQ-027 Latency from last input transfer to first o_out_valid SHALL be 5 cycles with an idle, ready engine.

Reset
REQ-028 On i_rst_n=0: state=LOAD, k=0, j=0, o_mm_trigger=0, o_out_valid=0, o_out_last=0, o_busy=0, o_in_ready=1 after release, operand and result registers cleared to 0.
REQ-029 Reset mid-operation SHALL discard any partial frame or undrained results; no trigger SHALL be issued after release until a full 2*NELEM frame arrives.

Structure
REQ-030 Package matmul_pkg SHALL hold ELEM_W, N, NELEM defaults and the FSM state enum.
REQ-031 No sub-module required; the block SHALL connect externally to the matmul engine ports.

Verification
REQ-032 A=identity, B=1..9 -> outputs 1,2,...,9, o_out_last on 9th.
REQ-033 A all 1, B all 1 -> nine outputs of 3.
REQ-034 A all 127, B all 1 -> nine outputs of 125 (381 mod 128).
REQ-035 i_out_ready low 5 cycles at j=4 -> o_out_data held at result[4], stream resumes intact.
REQ-036 Reset pulse after 10 input elements, then full frame A=identity, B=2I -> outputs 2,0,0,0,2,0,0,0,2.
REQ-037 i_mm_ready held 0 for 8 cycles at LAUNCH -> no trigger until ready rises, then exactly one trigger pulse.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul sequencer: default geometry and FSM state encoding.
package matmul_pkg;

  localparam int unsigned DEF_ELEM_W = 7;
  localparam int unsigned DEF_N      = 3;
  localparam int unsigned DEF_NELEM  = DEF_N * DEF_N;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_SETTLE,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/matmul_sequencer_if.sv
// Bundle of the sequencer's stream and engine signals.
//   input stream : i_in_valid, i_in_data -> o_in_ready
//   engine side  : o_mm_trigger, o_mm_a, o_mm_b, i_mm_ready, i_mm_result
//   result stream: o_out_valid, o_out_data, o_out_last <- i_out_ready
//   status       : o_busy
// Matrices are packed row-major, element i at [i*ELEM_W +: ELEM_W].
interface matmul_sequencer_if
  import matmul_pkg::*;
#(
  parameter int unsigned ELEM_W = DEF_ELEM_W,
  parameter int unsigned N      = DEF_N
);
  localparam int unsigned NELEM = N * N;
  localparam int unsigned MAT_W = NELEM * ELEM_W;

  logic              i_in_valid;
  logic [ELEM_W-1:0] i_in_data;
  logic              o_in_ready;
  logic              o_mm_trigger;
  logic [MAT_W-1:0]  o_mm_a;
  logic [MAT_W-1:0]  o_mm_b;
  logic              i_mm_ready;
  logic [MAT_W-1:0]  i_mm_result;
  logic              o_out_valid;
  logic [ELEM_W-1:0] o_out_data;
  logic              o_out_last;
  logic              i_out_ready;
  logic              o_busy;

  // Sequencer view.
  modport slave (
    input  i_in_valid, i_in_data, i_mm_ready, i_mm_result, i_out_ready,
    output o_in_ready, o_mm_trigger, o_mm_a, o_mm_b,
           o_out_valid, o_out_data, o_out_last, o_busy
  );

  // Environment view (upstream source, engine, downstream sink).
  modport master (
    output i_in_valid, i_in_data, i_mm_ready, i_mm_result, i_out_ready,
    input  o_in_ready, o_mm_trigger, o_mm_a, o_mm_b,
           o_out_valid, o_out_data, o_out_last, o_busy
  );

endinterface

// File: rtl/matmul_sequencer.sv
// Collects an A then B matrix from an element stream, launches an external
// matmul engine, waits for completion and streams the result back out.
// Ports:
//   i_clk   - clock, rising edge
//   i_rst_n - asynchronous active-low reset
//   bus     - matmul_sequencer_if.slave (input stream, engine, result stream, busy)
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int unsigned ELEM_W = DEF_ELEM_W,
  parameter int unsigned N      = DEF_N
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  matmul_sequencer_if.slave  bus
);

  localparam int unsigned NELEM = N * N;
  localparam int unsigned MAT_W = NELEM * ELEM_W;
  localparam int unsigned KW    = $clog2(2 * NELEM + 1);
  localparam int unsigned JW    = $clog2(NELEM + 1);
  localparam int unsigned CW    = 2;

  localparam logic [KW-1:0] K_LAST = KW'(2 * NELEM - 1);
  localparam logic [JW-1:0] J_LAST = JW'(NELEM - 1);
  localparam logic [CW-1:0] C_LAST = CW'(3);

  state_e            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [JW-1:0]     j_q, j_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [MAT_W-1:0]  a_q, a_d;
  logic [MAT_W-1:0]  b_q, b_d;
  logic [MAT_W-1:0]  res_q, res_d;
  logic              trig_q, trig_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              out_valid_q, out_valid_d;
  logic [ELEM_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;

  // Next-state and next-output logic; outputs are decoded from the next state.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    j_d        = j_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    trig_d     = 1'b0;
    out_data_d = out_data_q;
    out_last_d = out_last_q;

    case (state_q)
      ST_LOAD: begin
        if (bus.i_in_valid && in_ready_q) begin
          if (k_q < KW'(NELEM)) a_d[32'(k_q) * ELEM_W +: ELEM_W] = bus.i_in_data;
          else                  b_d[(32'(k_q) - NELEM) * ELEM_W +: ELEM_W] = bus.i_in_data;
          if (k_q == K_LAST) begin
            k_d     = '0;
            state_d = ST_LAUNCH;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      ST_LAUNCH: begin
        if (bus.i_mm_ready) begin
          trig_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_WAIT_BUSY;
        end
      end
      // Engine must drop ready to acknowledge; otherwise the trigger was lost, relaunch.
      ST_WAIT_BUSY: begin
        if (!bus.i_mm_ready)     state_d = ST_WAIT_DONE;
        else if (cnt_q == C_LAST) state_d = ST_LAUNCH;
        else                     cnt_d = cnt_q + CW'(1);
      end
      ST_WAIT_DONE: begin
        if (bus.i_mm_ready) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        res_d      = bus.i_mm_result;
        j_d        = '0;
        out_data_d = bus.i_mm_result[ELEM_W-1:0];
        out_last_d = (J_LAST == '0);
        state_d    = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (out_valid_q && bus.i_out_ready) begin
          if (j_q == J_LAST) begin
            j_d        = '0;
            out_last_d = 1'b0;
            state_d    = ST_LOAD;
          end else begin
            j_d        = j_q + JW'(1);
            out_data_d = res_q[(32'(j_q) + 1) * ELEM_W +: ELEM_W];
            out_last_d = ((j_q + JW'(1)) == J_LAST);
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase

    in_ready_d  = (state_d == ST_LOAD);
    busy_d      = (state_d != ST_LOAD);
    out_valid_d = (state_d == ST_DRAIN);
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_LOAD;
      k_q         <= '0;
      j_q         <= '0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      trig_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      j_q         <= j_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      trig_q      <= trig_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.o_in_ready   = in_ready_q;
  assign bus.o_mm_trigger = trig_q;
  assign bus.o_mm_a       = a_q;
  assign bus.o_mm_b       = b_q;
  assign bus.o_out_valid  = out_valid_q;
  assign bus.o_out_data   = out_data_q;
  assign bus.o_out_last   = out_last_q;
  assign bus.o_busy       = busy_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer with a small behavioural engine model.
module tb_matmul_sequencer;
  import matmul_pkg::*;

  localparam int unsigned EW = 7;
  localparam int unsigned NN = 3;
  localparam int unsigned NE = NN * NN;
  localparam int unsigned MW = NE * EW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matmul_sequencer_if #(.ELEM_W(EW), .N(NN)) bus ();

  matmul_sequencer #(.ELEM_W(EW), .N(NN)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // Engine model: acknowledges a trigger by dropping ready for one cycle.
  logic          eng_ready;
  logic          eng_deaf;
  logic          hold_lo;
  logic [MW-1:0] eng_res;

  function automatic logic [MW-1:0] mat_mul(input logic [MW-1:0] a, input logic [MW-1:0] b);
    logic [MW-1:0] r;
    int acc;
    r = '0;
    for (int i = 0; i < 3; i++)
      for (int c = 0; c < 3; c++) begin
        acc = 0;
        for (int k = 0; k < 3; k++)
          acc += int'(a[(i*3+k)*EW +: EW]) * int'(b[(k*3+c)*EW +: EW]);
        r[(i*3+c)*EW +: EW] = EW'(acc);
      end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_ready <= 1'b1;
      eng_res   <= '0;
    end else if (bus.o_mm_trigger && !eng_deaf) begin
      eng_ready <= 1'b0;
      eng_res   <= mat_mul(bus.o_mm_a, bus.o_mm_b);
    end else if (!eng_ready) begin
      eng_ready <= 1'b1;
    end
  end

  assign bus.i_mm_ready  = eng_ready & ~hold_lo;
  assign bus.i_mm_result = eng_res;

  int n_checks = 0;
  int n_fail   = 0;

  logic [MW-1:0] m_id, m_b19, m_ones, m_127, m_2i, m_threes, m_125, m_b19x2;

  function automatic logic [MW-1:0] pack9(input int unsigned v [9]);
    logic [MW-1:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) r[i*EW +: EW] = EW'(v[i]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_elem(input logic [EW-1:0] d);
    logic rdy;
    logic done;
    done = 1'b0;
    bus.i_in_valid = 1'b1;
    bus.i_in_data  = d;
    for (int t = 0; t < 100 && !done; t++) begin
      rdy = bus.o_in_ready;
      tick();
      if (rdy) done = 1'b1;
    end
    bus.i_in_valid = 1'b0;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL send_elem: in_ready never high, data=%0d", d);
    end
  endtask

  task automatic send_frame(input logic [MW-1:0] a, input logic [MW-1:0] b);
    for (int i = 0; i < 9; i++) send_elem(a[i*EW +: EW]);
    for (int i = 0; i < 9; i++) send_elem(b[i*EW +: EW]);
  endtask

  // Drains nine results, optionally stalling five cycles at element stall_at.
  task automatic drain_check(input string name, input logic [MW-1:0] exp, input int stall_at);
    int t;
    logic [EW-1:0] e;
    t = 0;
    while (bus.o_out_valid !== 1'b1 && t < 100) begin
      tick();
      t++;
    end
    n_checks++;
    if (bus.o_out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: out_valid timeout, got %b expected 1", name, bus.o_out_valid);
      return;
    end
    for (int j = 0; j < 9; j++) begin
      e = exp[j*EW +: EW];
      if (j == stall_at) begin
        bus.i_out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          n_checks++;
          if (bus.o_out_data !== e || bus.o_out_valid !== 1'b1 || bus.o_out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL %s stall j=%0d: data=%0d valid=%b last=%b expected %0d 1 0",
                     name, j, bus.o_out_data, bus.o_out_valid, bus.o_out_last, e);
          end
        end
        bus.i_out_ready = 1'b1;
      end
      n_checks++;
      if (bus.o_out_data !== e || bus.o_out_valid !== 1'b1 || bus.o_out_last !== 1'(j == 8)) begin
        n_fail++;
        $display("FAIL %s j=%0d: data=%0d valid=%b last=%b expected %0d 1 %b",
                 name, j, bus.o_out_data, bus.o_out_valid, bus.o_out_last, e, 1'(j == 8));
      end
      tick();
    end
    n_checks++;
    if (bus.o_in_ready !== 1'b1 || bus.o_out_valid !== 1'b0 || bus.o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s post-drain: in_ready=%b out_valid=%b busy=%b expected 1 0 0",
               name, bus.o_in_ready, bus.o_out_valid, bus.o_busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (bus.o_in_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset ready/busy: in_ready=%b busy=%b expected 1 0", bus.o_in_ready, bus.o_busy);
    end
    n_checks++;
    if (bus.o_mm_trigger !== 1'b0 || bus.o_out_valid !== 1'b0 || bus.o_out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset outputs: trigger=%b out_valid=%b out_last=%b expected 0 0 0",
               bus.o_mm_trigger, bus.o_out_valid, bus.o_out_last);
    end
    n_checks++;
    if (bus.o_mm_a !== '0 || bus.o_mm_b !== '0 || bus.o_out_data !== '0) begin
      n_fail++;
      $display("FAIL reset operands: a=%h b=%h data=%0d expected 0", bus.o_mm_a, bus.o_mm_b, bus.o_out_data);
    end
  endtask

  task automatic test_identity();
    int lat;
    int tc;
    send_frame(m_id, m_b19);
    lat = 0;
    tc = 0;
    while (bus.o_out_valid !== 1'b1 && lat < 50) begin
      if (bus.o_mm_trigger === 1'b1) tc++;
      tick();
      lat++;
    end
    n_checks++;
    if (lat != 5) begin
      n_fail++;
      $display("FAIL identity latency: got %0d cycles expected 5", lat);
    end
    n_checks++;
    if (tc != 1) begin
      n_fail++;
      $display("FAIL identity triggers: got %0d expected 1", tc);
    end
    drain_check("identity", m_b19, -1);
  endtask

  task automatic test_all_ones();
    send_frame(m_ones, m_ones);
    drain_check("all_ones", m_threes, -1);
  endtask

  task automatic test_wrap();
    send_frame(m_127, m_ones);
    drain_check("wrap", m_125, -1);
  endtask

  // Stall the result stream and keep input valid asserted while busy.
  task automatic test_backpressure();
    int t;
    send_frame(m_id, m_b19);
    bus.i_in_valid = 1'b1;
    bus.i_in_data  = 7'h55;
    t = 0;
    while (bus.o_out_valid !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    bus.i_in_valid = 1'b0;
    n_checks++;
    if (bus.o_in_ready !== 1'b0 || bus.o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure busy: in_ready=%b busy=%b expected 0 1", bus.o_in_ready, bus.o_busy);
    end
    drain_check("backpressure", m_b19, 4);
  endtask

  task automatic test_back_to_back();
    send_frame(m_ones, m_ones);
    drain_check("back_to_back", m_threes, -1);
  endtask

  task automatic test_reset_mid();
    int tc;
    for (int i = 0; i < 9; i++) send_elem(m_id[i*EW +: EW]);
    send_elem(m_b19[EW-1:0]);
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (bus.o_in_ready !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_mm_a !== '0) begin
      n_fail++;
      $display("FAIL reset_mid clear: in_ready=%b busy=%b a=%h expected 1 0 0",
               bus.o_in_ready, bus.o_busy, bus.o_mm_a);
    end
    rst_n = 1'b1;
    tc = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.o_mm_trigger === 1'b1 || bus.o_busy === 1'b1) tc++;
    end
    n_checks++;
    if (tc != 0) begin
      n_fail++;
      $display("FAIL reset_mid idle: got %0d trigger/busy cycles expected 0", tc);
    end
    send_frame(m_id, m_2i);
    drain_check("reset_mid", m_2i, -1);
  endtask

  task automatic test_launch_hold();
    int tc;
    int t;
    hold_lo = 1'b1;
    send_frame(m_ones, m_id);
    tc = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.o_mm_trigger === 1'b1) tc++;
    end
    n_checks++;
    if (tc != 0 || bus.o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL launch_hold: triggers=%0d busy=%b expected 0 1", tc, bus.o_busy);
    end
    n_checks++;
    if (bus.o_mm_a !== m_ones || bus.o_mm_b !== m_id) begin
      n_fail++;
      $display("FAIL launch_hold operands: a=%h b=%h expected %h %h", bus.o_mm_a, bus.o_mm_b, m_ones, m_id);
    end
    hold_lo = 1'b0;
    tc = 0;
    t = 0;
    while (bus.o_out_valid !== 1'b1 && t < 50) begin
      tick();
      t++;
      if (bus.o_mm_trigger === 1'b1) tc++;
    end
    n_checks++;
    if (tc != 1) begin
      n_fail++;
      $display("FAIL launch_hold release: triggers=%0d expected 1", tc);
    end
    drain_check("launch_hold", m_ones, -1);
  endtask

  // Engine ignores triggers: the sequencer relaunches every five cycles.
  task automatic test_retrigger();
    int tc;
    int t;
    eng_deaf = 1'b1;
    send_frame(m_2i, m_b19);
    t = 0;
    while (bus.o_mm_trigger !== 1'b1 && t < 10) begin
      tick();
      t++;
    end
    n_checks++;
    if (bus.o_mm_trigger !== 1'b1) begin
      n_fail++;
      $display("FAIL retrigger first: trigger=%b expected 1", bus.o_mm_trigger);
    end
    tc = 0;
    for (int i = 0; i < 11; i++) begin
      tick();
      if (bus.o_mm_trigger === 1'b1) tc++;
    end
    n_checks++;
    if (tc != 2) begin
      n_fail++;
      $display("FAIL retrigger count: got %0d expected 2", tc);
    end
    eng_deaf = 1'b0;
    drain_check("retrigger", m_b19x2, -1);
  endtask

  initial begin
    int unsigned v [9];
    bus.i_in_valid  = 1'b0;
    bus.i_in_data   = '0;
    bus.i_out_ready = 1'b1;
    eng_deaf = 1'b0;
    hold_lo  = 1'b0;
    v = '{1, 0, 0, 0, 1, 0, 0, 0, 1};           m_id     = pack9(v);
    v = '{1, 2, 3, 4, 5, 6, 7, 8, 9};           m_b19    = pack9(v);
    v = '{1, 1, 1, 1, 1, 1, 1, 1, 1};           m_ones   = pack9(v);
    v = '{127, 127, 127, 127, 127, 127, 127, 127, 127}; m_127 = pack9(v);
    v = '{2, 0, 0, 0, 2, 0, 0, 0, 2};           m_2i     = pack9(v);
    v = '{3, 3, 3, 3, 3, 3, 3, 3, 3};           m_threes = pack9(v);
    v = '{125, 125, 125, 125, 125, 125, 125, 125, 125}; m_125 = pack9(v);
    v = '{2, 4, 6, 8, 10, 12, 14, 16, 18};      m_b19x2  = pack9(v);

    test_reset();
    test_identity();
    test_all_ones();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_launch_hold();
    test_retrigger();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
